// File: rtl/sar_result_capture.sv
// sar_result_capture
// Receiving end of the SAR conversion interface. It watches the sequencer
// strobes, checks the sample/convert/latch framing and captures each finished
// 8-bit code on the rising edge of eoc_in. Results go into a first-word
// fall-through FIFO that is drained over a valid/ready stream.
//
// Optional feature, macro SAR_CAPTURE_AVG_EN: when defined, 2**AVG_LOG2
// consecutive captures are summed and one truncated average is pushed per
// block. When it is undefined, every capture pushes code_in directly and no
// accumulator logic exists.
module sar_result_capture #(
   parameter int DEPTH    = 4,
   parameter int AVG_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  code_in,
   input  logic        sample_clk_in,
   input  logic        reg_clk_in,
   input  logic        eoc_in,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        clr_flags,
   output logic        overflow,
   output logic        frame_err,
   output logic [15:0] conv_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   // Reject configurations the pointer arithmetic cannot support.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AVG_LOG2 < 1 || AVG_LOG2 > 7) begin : g_param_check
      $error("sar_result_capture: DEPTH must be a power of two >= 2 and AVG_LOG2 in 1..7");
   end

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SAMPLED    = 2'd1,
      ST_CONVERTING = 2'd2
   } state_e;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   logic             eoc_q, eoc_d;
   logic             cap_evt;

   state_e           state_q, state_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic             cap_legal;
   logic             frame_viol;

   logic             push_req;
   logic [7:0]       push_data;

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             ovf_q, ovf_d;
   logic             ferr_q, ferr_d;
   logic [15:0]      conv_cnt_q, conv_cnt_d;

   logic             full;
   logic             pop;
   logic             push_acc;
   logic             drop;

   // ------------------------------------------------------------------
   // EOC edge detect: one capture event per rising edge, however long
   // eoc_in stays high.
   // ------------------------------------------------------------------
   assign cap_evt = eoc_in & ~eoc_q;

   // Next value of the EOC history flop.
   always_comb begin
      eoc_d = eoc_in;
   end

   // EOC history register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (rst) begin
         eoc_q <= 1'b0;
      end else begin
         eoc_q <= eoc_d;
      end
   end

   // ------------------------------------------------------------------
   // Framing FSM
   // ------------------------------------------------------------------

   // State register and conversion bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Next-state logic: a capture always ends the frame; otherwise follow
   // the sample/convert sequence, restarting on a sample strobe mid-conversion.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      if (cap_evt) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (sample_clk_in) state_d = ST_SAMPLED;
            end
            ST_SAMPLED: begin
               if (!sample_clk_in) begin
                  state_d   = ST_CONVERTING;
                  bit_cnt_d = 4'd0;
               end
            end
            ST_CONVERTING: begin
               if (sample_clk_in) begin
                  state_d = ST_SAMPLED;
               end else if (bit_cnt_q != 4'd15) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // FSM outputs: capture legality and framing violations.
   always_comb begin
      cap_legal  = cap_evt && (state_q == ST_CONVERTING) &&
                   (bit_cnt_q >= 4'd8) && reg_clk_in;
      frame_viol = (cap_evt && !cap_legal) ||
                   (!cap_evt && (state_q == ST_CONVERTING) && sample_clk_in);
   end

   // ------------------------------------------------------------------
   // Push source
   // ------------------------------------------------------------------
`ifdef SAR_CAPTURE_AVG_EN
   localparam int ACC_W = 8 + AVG_LOG2;

   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [AVG_LOG2-1:0] nsmp_q, nsmp_d;
   logic [ACC_W-1:0]    acc_sum;

   // Accumulate captures; the last one of a block pushes the truncated mean.
   // A framing violation discards the partial block.
   always_comb begin
      acc_d     = acc_q;
      nsmp_d    = nsmp_q;
      push_req  = 1'b0;
      acc_sum   = acc_q + {{AVG_LOG2{1'b0}}, code_in};
      push_data = acc_sum[ACC_W-1:AVG_LOG2];
      if (frame_viol) begin
         acc_d  = '0;
         nsmp_d = '0;
      end else if (cap_evt) begin
         if (&nsmp_q) begin
            push_req = 1'b1;
            acc_d    = '0;
            nsmp_d   = '0;
         end else begin
            acc_d  = acc_sum;
            nsmp_d = nsmp_q + {{(AVG_LOG2-1){1'b0}}, 1'b1};
         end
      end
   end

   // Accumulator and sample-count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         nsmp_q <= '0;
      end else begin
         acc_q  <= acc_d;
         nsmp_q <= nsmp_d;
      end
   end
`else
   // Every capture event pushes the sequencer code as-is.
   always_comb begin
      push_req  = cap_evt;
      push_data = code_in;
   end
`endif

   // ------------------------------------------------------------------
   // FIFO and status
   // ------------------------------------------------------------------
   assign full     = (count_q == CNT_W'(DEPTH));
   assign pop      = (count_q != '0) && out_ready;
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign push_acc = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   // Pointer, occupancy, head register and counter updates.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      conv_cnt_d = conv_cnt_q;
      out_data_d = out_data_q;

      if (push_acc) begin
         wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         conv_cnt_d = conv_cnt_q + 16'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_acc, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Head register tracks mem[rd_ptr]; when the new head is the entry
      // being written this cycle, forward it. Holds when the FIFO drains.
      if (count_d != '0) begin
         if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
            out_data_d = push_data;
         end else begin
            out_data_d = mem_q[rd_ptr_d];
         end
      end
   end

   // Sticky flags: a set in the same cycle as clr_flags wins.
   always_comb begin
      ovf_d  = drop       | (ovf_q  & ~clr_flags);
      ferr_d = frame_viol | (ferr_q & ~clr_flags);
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; occupancy and the head
      // register are reset, so stale entries are never visible.
      if (push_acc) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // FIFO control, head and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         out_data_q <= 8'd0;
         ovf_q      <= 1'b0;
         ferr_q     <= 1'b0;
         conv_cnt_q <= 16'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         out_data_q <= out_data_d;
         ovf_q      <= ovf_d;
         ferr_q     <= ferr_d;
         conv_cnt_q <= conv_cnt_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = (count_q != '0);
   assign overflow   = ovf_q;
   assign frame_err  = ferr_q;
   assign conv_count = conv_cnt_q;

endmodule

// File: tb/tb_sar_result_capture.sv
// Self-checking bench for sar_result_capture: directed scenarios with literal
// expectations plus randomized conversions, all compared every cycle against
// a queue-based behavioural model.
module tb_sar_result_capture;

   localparam int DEPTH    = 4;
   localparam int AVG_LOG2 = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  code_in;
   logic        sample_clk_in;
   logic        reg_clk_in;
   logic        eoc_in;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        clr_flags;
   logic        overflow;
   logic        frame_err;
   logic [15:0] conv_count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   bit rand_bg = 1'b0;

   sar_result_capture #(.DEPTH(DEPTH), .AVG_LOG2(AVG_LOG2)) dut (
      .clk           (clk),
      .rst           (rst),
      .code_in       (code_in),
      .sample_clk_in (sample_clk_in),
      .reg_clk_in    (reg_clk_in),
      .eoc_in        (eoc_in),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .clr_flags     (clr_flags),
      .overflow      (overflow),
      .frame_err     (frame_err),
      .conv_count    (conv_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: result queue, sticky flags, and a framing tracker
   // based on how many edges have elapsed since the conversion began.
   // ------------------------------------------------------------------
   byte unsigned m_q[$];
   logic [7:0]   m_data;
   bit           m_ovf, m_ferr;
   logic [15:0]  m_cnt;
   bit           m_eoc_prev, m_samp, m_conv;
   int           m_start, m_cyc;
   int           m_acc, m_n;

   always @(posedge clk) begin : model
      bit ev, legal, viol, pop, push, ovf_set;
      logic [7:0] pdata;
      if (rst) begin
         m_q.delete();
         m_data = 8'd0; m_ovf = 0; m_ferr = 0; m_cnt = 16'd0;
         m_eoc_prev = 0; m_samp = 0; m_conv = 0; m_acc = 0; m_n = 0;
      end else begin
         ev = eoc_in && !m_eoc_prev;
         // The conversion needs eight full cycles after its start cycle.
         legal = ev && m_conv && (m_cyc - m_start >= 9) && reg_clk_in;
         viol = (ev && !legal) || (!ev && m_conv && sample_clk_in);
         pop = (m_q.size() > 0) && out_ready;
         push = 0; ovf_set = 0; pdata = code_in;
`ifdef SAR_CAPTURE_AVG_EN
         if (viol) begin
            m_acc = 0; m_n = 0;
         end else if (ev) begin
            m_acc += int'(code_in); m_n++;
            if (m_n == (1 << AVG_LOG2)) begin
               push = 1; pdata = 8'(m_acc >> AVG_LOG2); m_acc = 0; m_n = 0;
            end
         end
`else
         push = ev;
`endif
         if (ev) begin
            m_samp = 0; m_conv = 0;
         end else if (m_conv && sample_clk_in) begin
            m_conv = 0; m_samp = 1;
         end else if (m_samp && !sample_clk_in) begin
            m_samp = 0; m_conv = 1; m_start = m_cyc;
         end else if (!m_samp && !m_conv && sample_clk_in) begin
            m_samp = 1;
         end
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (m_q.size() < DEPTH) begin
               m_q.push_back(pdata); m_cnt = m_cnt + 16'd1;
            end else begin
               ovf_set = 1;
            end
         end
         m_ovf  = ovf_set || (m_ovf && !clr_flags);
         m_ferr = viol || (m_ferr && !clr_flags);
         if (m_q.size() > 0) m_data = m_q[0];
         m_eoc_prev = eoc_in;
         m_cyc++;
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp out_valid",  32'(out_valid),  32'(m_q.size() > 0));
         check("cmp out_data",   32'(out_data),   32'(m_data));
         check("cmp overflow",   32'(overflow),   32'(m_ovf));
         check("cmp frame_err",  32'(frame_err),  32'(m_ferr));
         check("cmp conv_count", 32'(conv_count), 32'(m_cnt));
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change just after the falling edge)
   // ------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
      if (rand_bg) begin
         out_ready = 1'($urandom % 2);
         clr_flags = ($urandom % 16) == 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic convert(input logic [7:0] code, input int zeros, input bit reg_ok,
                          input bit ready_at_eoc, input int eoc_len);
      sample_clk_in = 1'b1; tick(); sample_clk_in = 1'b0;
      repeat (zeros) tick();
      code_in = code; eoc_in = 1'b1; reg_clk_in = reg_ok;
      if (ready_at_eoc) out_ready = 1'b1;
      tick();
      if (ready_at_eoc) out_ready = 1'b0;
      reg_clk_in = 1'b0; code_in = 8'($urandom);
      repeat (eoc_len - 1) tick();
      eoc_in = 1'b0; tick();
   endtask

   task automatic drain_expect(input string name, input logic [7:0] exp);
      check(name, 32'(out_data), 32'(exp));
      tick();
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      rst = 1'b1; code_in = 8'd0; sample_clk_in = 1'b0; reg_clk_in = 1'b0;
      eoc_in = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
      tick(); chk_en = 1'b1; tick();
      check("reset out_valid",  32'(out_valid),  0);
      check("reset out_data",   32'(out_data),   0);
      check("reset overflow",   32'(overflow),   0);
      check("reset frame_err",  32'(frame_err),  0);
      check("reset conv_count", 32'(conv_count), 0);
      rst = 1'b0;

`ifdef SAR_CAPTURE_AVG_EN
      convert(8'h10, 9, 1, 0, 1);
      convert(8'h20, 9, 1, 0, 1);
      convert(8'h30, 9, 1, 0, 1);
      check("avg no early push", 32'(out_valid), 0);
      convert(8'h41, 9, 1, 0, 1);
      check("avg out_valid",  32'(out_valid),  1);
      check("avg out_data",   32'(out_data),   32'h28);
      check("avg conv_count", 32'(conv_count), 1);
      check("avg model data", 32'(m_data),     32'h28);
`else
      // Nominal conversion.
      convert(8'hA5, 9, 1, 0, 1);
      check("nominal out_valid",  32'(out_valid),  1);
      check("nominal out_data",   32'(out_data),   32'hA5);
      check("nominal conv_count", 32'(conv_count), 1);
      check("nominal frame_err",  32'(frame_err),  0);
      check("model nominal data", 32'(m_data),     32'hA5);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("pop to empty valid",  32'(out_valid), 0);
      check("empty holds data",    32'(out_data),  32'hA5);

      // Backpressure and overflow.
      do_reset();
      for (int i = 1; i <= 5; i++) convert(8'(i), 9, 1, 0, 1);
      check("bp overflow",     32'(overflow),   1);
      check("bp conv_count",   32'(conv_count), 4);
      check("model bp depth",  32'(m_q.size()), 4);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) drain_expect("bp drain order", 8'(i));
      out_ready = 1'b0;
      check("bp drained", 32'(out_valid), 0);

      // Full FIFO with push and pop in the same cycle.
      do_reset();
      for (int i = 0; i < 4; i++) convert(8'h11 + 8'(i), 9, 1, 0, 1);
      convert(8'h77, 9, 1, 1, 1);
      check("full pp overflow",   32'(overflow),   0);
      check("full pp conv_count", 32'(conv_count), 5);
      out_ready = 1'b1;
      drain_expect("full pp drain 0", 8'h12);
      drain_expect("full pp drain 1", 8'h13);
      drain_expect("full pp drain 2", 8'h14);
      drain_expect("full pp drain 3", 8'h77);
      out_ready = 1'b0;
      check("full pp drained", 32'(out_valid), 0);

      // Framing error: EOC too soon after the sample phase.
      do_reset();
      convert(8'h3C, 3, 1, 0, 1);
      check("short conv frame_err", 32'(frame_err),  1);
      check("short conv captured",  32'(out_data),   32'h3C);
      check("short conv count",     32'(conv_count), 1);
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      check("clr frame_err", 32'(frame_err), 0);
      // Abort coinciding with clr_flags: the set wins.
      sample_clk_in = 1'b1; tick(); sample_clk_in = 1'b0; tick(); tick();
      sample_clk_in = 1'b1; clr_flags = 1'b1; tick();
      sample_clk_in = 1'b0; clr_flags = 1'b0;
      check("set beats clr", 32'(frame_err), 1);

      // Reset mid-conversion, then an EOC with no fresh sample phase.
      tick(); repeat (4) tick();
      do_reset();
      check("mid rst out_valid",  32'(out_valid),  0);
      check("mid rst out_data",   32'(out_data),   0);
      check("mid rst frame_err",  32'(frame_err),  0);
      check("mid rst conv_count", 32'(conv_count), 0);
      repeat (10) tick();
      code_in = 8'h5A; eoc_in = 1'b1; reg_clk_in = 1'b1; tick();
      eoc_in = 1'b0; reg_clk_in = 1'b0; tick();
      check("post rst frame_err", 32'(frame_err),  1);
      check("post rst captured",  32'(out_data),   32'h5A);
      check("post rst count",     32'(conv_count), 1);
`endif

      // Randomized conversions with background backpressure and flag clears.
      do_reset();
      rand_bg = 1'b1;
      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 3)) tick();
         if ($urandom % 40 == 0) do_reset();
         if ($urandom % 12 == 0) begin
            sample_clk_in = 1'b1; tick(); sample_clk_in = 1'b0; tick();
         end
         convert(8'($urandom), int'($urandom_range(1, 13)), ($urandom % 8) != 0, 1'b0,
                 int'($urandom_range(1, 3)));
      end
      rand_bg = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
